// File: rtl/au_pkg.sv
// Shared definitions for the au instruction sequencer: opcodes, FSM states
// and instruction field positions.
package au_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_MOVA = 4'b0100;
  localparam logic [3:0] OP_MOVB = 4'b0101;
  localparam logic [3:0] OP_OUT  = 4'b1101;

  localparam int OP_HI = 7;
  localparam int OP_LO = 4;
  localparam int RD_HI = 3;
  localparam int RD_LO = 2;
  localparam int RS_HI = 1;
  localparam int RS_LO = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_IMM  = 2'd1,
    S_EXEC = 2'd2,
    S_OUTW = 2'd3
  } state_t;

  // NOP counts as legal; it simply never reaches EXEC.
  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_MOVA, OP_MOVB, OP_OUT: op_legal = 1'b1;
      default:                                          op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/au_regfile.sv
// Four-entry register file: two asynchronous read ports, one synchronous
// write port, cleared by the asynchronous reset.
module au_regfile #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [1:0]    rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic          we,
  input  logic [1:0]    wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] regs [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

endmodule

// File: rtl/au_seq.sv
// Multi-cycle instruction sequencer for the 8-bit signed AU: decodes a byte
// stream, drives the AU for one cycle per arithmetic op and writes results back.
module au_seq
  import au_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             au_en,
  output logic [3:0]       au_ac,
  output logic [DW-1:0]    au_a,
  output logic [DW-1:0]    au_b,
  input  logic [DW-1:0]    au_t,
  input  logic             au_gf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             gf,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  state_t        state, state_next;
  logic [3:0]    op;
  logic [1:0]    rd, rs;
  logic [DW-1:0] imm;
  logic [DW-1:0] rs_data, rd_data;
  logic [3:0]    in_op;
  logic          in_fire, in_legal, reg_we, retire;

  assign in_op    = in_data[OP_HI:OP_LO];
  assign in_fire  = in_valid & in_ready;
  assign in_legal = op_legal(in_op);

  au_regfile #(.DW(DW)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (rs),
    .ra_data (rs_data),
    .rb_addr (rd),
    .rb_data (rd_data),
    .we      (reg_we),
    .wa      (rd),
    .wd      (au_t)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (in_fire) begin
          if (in_op == OP_MOVB)                   state_next = S_IMM;
          else if (in_op == OP_NOP || !in_legal)  state_next = S_IDLE;
          else                                    state_next = S_EXEC;
        end
      end
      S_IMM:   if (in_fire) state_next = S_EXEC;
      S_EXEC:  state_next = (op == OP_OUT) ? S_OUTW : S_IDLE;
      S_OUTW:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // AU drive is zero outside EXEC so the shared AU output floats.
  always_comb begin
    in_ready = 1'b0;
    au_en    = 1'b0;
    au_ac    = 4'b0000;
    au_a     = '0;
    au_b     = '0;
    busy     = (state != S_IDLE);
    case (state)
      S_IDLE, S_IMM: in_ready = 1'b1;
      S_EXEC: begin
        au_en = 1'b1;
        au_ac = op;
        au_a  = (op == OP_MOVB) ? imm : rs_data;
        au_b  = rd_data;
      end
      default: ;
    endcase
  end

  assign reg_we = (state == S_EXEC) && (op != OP_OUT);
  assign retire = ((state == S_IDLE) && in_fire && (in_op == OP_NOP || !in_legal))
                || reg_we
                || ((state == S_OUTW) && out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op  <= OP_NOP;
      rd  <= '0;
      rs  <= '0;
      imm <= '0;
    end else begin
      if (state == S_IDLE && in_fire) begin
        op <= in_op;
        rd <= in_data[RD_HI:RD_LO];
        rs <= in_data[RS_HI:RS_LO];
      end
      if (state == S_IMM && in_fire) imm <= DW'(in_data);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gf        <= 1'b0;
      err       <= 1'b0;
      retired   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (state == S_EXEC && op == OP_SUB) gf <= au_gf;
      if (state == S_IDLE && in_fire && !in_legal) err <= 1'b1;
      if (retire && retired != '1) retired <= retired + CNT_W'(1);
      if (state == S_EXEC && op == OP_OUT) begin
        out_valid <= 1'b1;
        out_data  <= au_t;
      end else if (state == S_OUTW && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_au_seq.sv
// Directed self-checking bench for au_seq; models the AU (t = b op a, signed
// greater flag) and reads registers back through OUT instructions.
module tb_au_seq;

  localparam int DW    = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = 8'h00;
  logic             au_en;
  logic [3:0]       au_ac;
  logic [DW-1:0]    au_a, au_b, au_t;
  logic             au_gf;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    out_data;
  logic             gf, busy, err;
  logic [CNT_W-1:0] retired;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int accept_cyc = 0;
  int en_cnt   = 0;
  int sub_cnt  = 0;
  logic [3:0] last_ac = 4'b0000;

  au_seq #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .au_en(au_en), .au_ac(au_ac), .au_a(au_a), .au_b(au_b),
    .au_t(au_t), .au_gf(au_gf),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .gf(gf), .busy(busy), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  // Behavioural AU: result is b-a for SUB, b+a for ADD, pass-through of a otherwise.
  always_comb begin
    au_t  = '0;
    au_gf = 1'b0;
    if (au_en) begin
      case (au_ac)
        4'b1000: au_t = au_b + au_a;
        4'b1001: au_t = au_b - au_a;
        default: au_t = au_a;
      endcase
      au_gf = $signed(au_b) > $signed(au_a);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (au_en) begin
      en_cnt  <= en_cnt + 1;
      last_ac <= au_ac;
      if (au_ac == 4'b1001) sub_cnt <= sub_cnt + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int k;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL send_byte_timeout byte=%h in_ready=%b required 1", b, in_ready);
    end else begin
      @(posedge clk);
      #1;
      accept_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wait_idle_timeout busy=%b required 0", busy);
    end
  endtask

  task automatic read_reg(input logic [1:0] r, output logic [7:0] v);
    int k;
    out_ready = 1'b1;
    send_byte({4'b1101, 2'b00, r});
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    v = out_valid ? out_data : 8'hxx;
    wait_idle();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("[TB] FAIL reset_in_ready got %b exp 1", in_ready); end
    n_checks++; if (au_en !== 1'b0 || au_ac !== 4'b0000 || au_a !== 8'h00 || au_b !== 8'h00)
      begin n_fail++; $display("[TB] FAIL reset_au got en=%b ac=%b a=%h b=%h exp 0", au_en, au_ac, au_a, au_b); end
    n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h00)
      begin n_fail++; $display("[TB] FAIL reset_out got v=%b d=%h exp 0/00", out_valid, out_data); end
    n_checks++; if (gf !== 1'b0 || err !== 1'b0)
      begin n_fail++; $display("[TB] FAIL reset_flags got gf=%b err=%b exp 0/0", gf, err); end
    n_checks++; if (retired !== 16'd0)  begin n_fail++; $display("[TB] FAIL reset_retired got %0d exp 0", retired); end
    rst = 1'b0;
  endtask

  task automatic test_sub();
    int e0, s0;
    logic [7:0] v;
    send_byte(8'h54); send_byte(8'h05);
    send_byte(8'h58); send_byte(8'h03);
    wait_idle();
    e0 = en_cnt; s0 = sub_cnt;
    send_byte(8'h96);
    wait_idle();
    n_checks++; if (sub_cnt - s0 !== 1 || en_cnt - e0 !== 1)
      begin n_fail++; $display("[TB] FAIL sub_one_cycle got sub=%0d en=%0d exp 1/1", sub_cnt - s0, en_cnt - e0); end
    n_checks++; if (gf !== 1'b1)        begin n_fail++; $display("[TB] FAIL sub_gf got %b exp 1", gf); end
    n_checks++; if (retired !== 16'd3)  begin n_fail++; $display("[TB] FAIL sub_retired got %0d exp 3", retired); end
    read_reg(2'd1, v);
    n_checks++; if (v !== 8'h02)        begin n_fail++; $display("[TB] FAIL sub_r1 got %h exp 02", v); end
    n_checks++; if (retired !== 16'd4)  begin n_fail++; $display("[TB] FAIL out_retired got %0d exp 4", retired); end
  endtask

  task automatic test_add_wrap();
    logic [7:0] v;
    send_byte(8'h50); send_byte(8'h7F);
    send_byte(8'h5C); send_byte(8'h01);
    send_byte(8'h83);
    wait_idle();
    n_checks++; if (last_ac !== 4'b1000) begin n_fail++; $display("[TB] FAIL add_ac got %b exp 1000", last_ac); end
    n_checks++; if (gf !== 1'b1)         begin n_fail++; $display("[TB] FAIL add_gf_kept got %b exp 1", gf); end
    read_reg(2'd0, v);
    n_checks++; if (v !== 8'h80)         begin n_fail++; $display("[TB] FAIL add_wrap_r0 got %h exp 80", v); end
  endtask

  task automatic test_signed_sub();
    logic [7:0] v;
    send_byte(8'h50); send_byte(8'hFE);
    send_byte(8'h54); send_byte(8'h01);
    send_byte(8'h91);
    wait_idle();
    n_checks++; if (gf !== 1'b0)  begin n_fail++; $display("[TB] FAIL signed_gf got %b exp 0", gf); end
    read_reg(2'd0, v);
    n_checks++; if (v !== 8'hFD)  begin n_fail++; $display("[TB] FAIL signed_r0 got %h exp FD", v); end
  endtask

  task automatic test_out_stall();
    int k, hi_cnt, bad_data, bad_rdy;
    out_ready = 1'b0;
    send_byte(8'hD2);
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    hi_cnt = 0; bad_data = 0; bad_rdy = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) out_ready = 1'b1;
      if (out_valid) hi_cnt++;
      if (out_data !== 8'h03) bad_data++;
      if (in_ready !== 1'b0) bad_rdy++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_checks++; if (hi_cnt !== 6)   begin n_fail++; $display("[TB] FAIL outw_valid_cycles got %0d exp 6", hi_cnt); end
    n_checks++; if (bad_data !== 0) begin n_fail++; $display("[TB] FAIL outw_data_stable got %0d bad exp 0", bad_data); end
    n_checks++; if (bad_rdy !== 0)  begin n_fail++; $display("[TB] FAIL outw_in_ready got %0d bad exp 0", bad_rdy); end
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0)
      begin n_fail++; $display("[TB] FAIL outw_done got v=%b busy=%b exp 0/0", out_valid, busy); end
  endtask

  task automatic test_illegal();
    int e0;
    logic [CNT_W-1:0] r0;
    logic [7:0] v;
    e0 = en_cnt; r0 = retired;
    send_byte(8'h3A);
    send_byte(8'h00);
    wait_idle();
    n_checks++; if (err !== 1'b1)          begin n_fail++; $display("[TB] FAIL illegal_err got %b exp 1", err); end
    n_checks++; if (en_cnt - e0 !== 0)     begin n_fail++; $display("[TB] FAIL illegal_au_en got %0d exp 0", en_cnt - e0); end
    n_checks++; if (retired !== r0 + 16'd2) begin n_fail++; $display("[TB] FAIL illegal_retired got %0d exp %0d", retired, r0 + 16'd2); end
    read_reg(2'd1, v);
    n_checks++; if (v !== 8'h01)  begin n_fail++; $display("[TB] FAIL illegal_r1 got %h exp 01", v); end
    read_reg(2'd2, v);
    n_checks++; if (v !== 8'h03)  begin n_fail++; $display("[TB] FAIL illegal_r2 got %h exp 03", v); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_sticky got %b exp 1", err); end
  endtask

  task automatic test_back_to_back();
    int c1;
    logic [7:0] v;
    send_byte(8'h85);
    c1 = accept_cyc;
    send_byte(8'h85);
    n_checks++; if (accept_cyc - c1 !== 2) begin n_fail++; $display("[TB] FAIL b2b_spacing got %0d exp 2", accept_cyc - c1); end
    wait_idle();
    read_reg(2'd1, v);
    n_checks++; if (v !== 8'h04)  begin n_fail++; $display("[TB] FAIL b2b_hazard_r1 got %h exp 04", v); end
    n_checks++; if (gf !== 1'b0)  begin n_fail++; $display("[TB] FAIL b2b_gf got %b exp 0", gf); end
  endtask

  task automatic test_reset_imm();
    int e0;
    logic [7:0] v;
    send_byte(8'h54);
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL imm_busy got %b exp 1", busy); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || err !== 1'b0 || retired !== 16'd0 || out_valid !== 1'b0 || au_en !== 1'b0)
      begin n_fail++; $display("[TB] FAIL async_reset got busy=%b err=%b ret=%0d ov=%b en=%b exp all 0", busy, err, retired, out_valid, au_en); end
    @(negedge clk);
    rst = 1'b0;
    e0 = en_cnt;
    send_byte(8'h85);
    wait_idle();
    n_checks++; if (en_cnt - e0 !== 1 || last_ac !== 4'b1000)
      begin n_fail++; $display("[TB] FAIL post_reset_add got en=%0d ac=%b exp 1/1000", en_cnt - e0, last_ac); end
    n_checks++; if (retired !== 16'd1) begin n_fail++; $display("[TB] FAIL post_reset_retired got %0d exp 1", retired); end
    read_reg(2'd1, v);
    n_checks++; if (v !== 8'h00)   begin n_fail++; $display("[TB] FAIL post_reset_r1 got %h exp 00", v); end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_add_wrap();
    test_signed_sub();
    test_out_stall();
    test_illegal();
    test_back_to_back();
    test_reset_imm();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout time=%0t limit=200000", $time);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/au_seq.md
Name: au_seq

Overview:
- Multi-cycle instruction sequencer for the 8-bit signed arithmetic unit (au).
- Accepts a byte-wide instruction stream over a valid/ready handshake and holds a 4-entry signed register file.
- Drives au_en/ac/a/b for exactly one cycle per arithmetic instruction, writes the AU result back, captures the greater-than flag, and emits OUT results on a valid/ready output port.
- Sits between the instruction source (switch/ROM front end) and the display/output logic.

Parameters:
- DW, 8: datapath width; must equal the AU width.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction/immediate byte valid.
- in_ready  out  1  sequencer accepts a byte this cycle.
- in_data  in  8  byte; instruction format [7:4]=op, [3:2]=rd, [1:0]=rs.
- au_en  out  1  AU enable.
- au_ac  out  4  AU opcode.
- au_a  out  DW  AU operand a.
- au_b  out  DW  AU operand b.
- au_t  in  DW  AU result.
- au_gf  in  1  AU greater flag.
- out_valid  out  1  OUT result valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  DW  OUT result.
- gf  out  1  registered greater flag.
- busy  out  1  state is not IDLE.
- err  out  1  sticky illegal-opcode flag.
- retired  out  CNT_W  instructions retired; saturates at all-ones.

Behaviour:
- Reset (async, any state): state=IDLE; R0..R3=0; gf=0; err=0; retired=0; out_valid=0; out_data=0; au_en=0; au_ac=0000; au_a=au_b=0.
- Opcodes:
  - 0000 NOP.
  - 1000 ADD: R[rd]=R[rd]+R[rs], wraps mod 2^8.
  - 1001 SUB: R[rd]=R[rd]-R[rs], wraps; gf=(R[rd]>R[rs]) signed.
  - 0100 MOVA: R[rd]=R[rs].
  - 0101 MOVB: R[rd]=imm; two-byte instruction, the second byte is the immediate.
  - 1101 OUT: out_data=R[rs].
  - Any other opcode is illegal.
- Operand mapping: au_a=R[rs], except au_a=imm for MOVB; au_b=R[rd]. The AU computes b-a, so SUB yields rd-rs.
- States:
  - IDLE: in_ready=1. On accepted byte:
    - NOP: retire, stay IDLE.
    - Illegal: err<=1, retire, stay IDLE; AU never enabled.
    - MOVB: go IMM.
    - Otherwise: go EXEC.
  - IMM: in_ready=1. Accepted byte latched as imm, go EXEC. The byte is never decoded as an opcode.
  - EXEC: exactly one cycle; au_en=1, au_ac=latched op, operands from registers.
    - At the clock edge ending EXEC, ADD/SUB/MOVA/MOVB write au_t to R[rd], retire, go IDLE.
    - SUB additionally loads gf<=au_gf; all other ops preserve gf.
    - OUT latches au_t to out_data, sets out_valid, goes OUTW; no register write.
  - OUTW: out_valid=1, out_data stable. When out_ready=1 at a clock edge: out_valid<=0, retire, go IDLE. out_ready already high on the first OUTW cycle completes in that cycle.
- Outside EXEC: au_en=0, au_ac=0000, au_a=au_b=0, so the AU output is tri-stated.
- in_ready=0 in EXEC and OUTW.
- Latency from instruction accept edge:
  - Register result visible 2 edges later.
  - MOVB: 3 edges after the opcode is accepted.
  - OUT: out_valid rises 2 edges after accept.
- Throughput: back-to-back ADDs retire one every 2 cycles.
- Register hazards: a following instruction reads the updated register; writeback completes before IDLE.
- retired: increments by 1 per retire and holds at 2^CNT_W-1.
- Reset mid-EXEC/IMM/OUTW aborts the instruction: no write, no retire, out_valid drops immediately.

Decomposition:
- Shared package au_pkg holds:
  - Opcode localparams: OP_NOP, OP_ADD, OP_SUB, OP_MOVA, OP_MOVB, OP_OUT.
  - State encoding: S_IDLE, S_IMM, S_EXEC, S_OUTW.
  - Instruction field bit positions.
- One sub-module, au_regfile: 4x DW, async read on two ports, one synchronous write port, async reset. The FSM stays in au_seq; the au itself is instantiated by the parent, not inside au_seq.

Test Plan:
- MOVB R1,0x05; MOVB R2,0x03; SUB R1,R2 -> R1=0x02, gf=1, retired=3, au_ac=1001 for exactly one cycle.
- MOVB R0,0x7F; MOVB R3,0x01; ADD R0,R3 -> R0=0x80 (wrap to -128), gf unchanged.
- SUB with R0=0xFE(-2), R1=0x01, op SUB rd=0 rs=1 -> R0=0xFD, gf=0 (signed compare, not unsigned).
- OUT R2 (R2=0x03) with out_ready held 0 for 5 cycles, then 1 -> out_valid high 6 cycles, out_data=0x03 stable, in_ready=0 throughout; IDLE after the handshake.
- Illegal byte 0x3A, then NOP -> err=1 sticky, au_en never asserted, registers unchanged, retired=2.
- rst asserted during IMM after MOVB opcode -> all outputs and registers 0 asynchronously; next byte 0x85 decodes as ADD, not as an immediate.
